pingpong_reader: RTL and testbench

Read side of the team's double-buffered register bank. A writer fills one of two banks of DEPTH words, then signals that bank as done. This block drains completed banks word by word onto a valid/ready stream and hands each bank back to the writer once it has been read out. It sits between the two-bank storage array (registered read port) and the downstream consumer.

---
 rtl/pp_pkg.sv | 18 +
 rtl/pingpong_reader.sv | 140 ++++++++++++++
 tb/tb_pingpong_reader.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pp_pkg.sv
// Shared types for the ping-pong register bank: reader FSM states, bank index
// type and the word-index width helper used by both the reader and the writer.
package pp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } pp_state_e;

  typedef logic pp_bank_t;

  // Word-index width for a bank of 'depth' words (never narrower than one bit).
  function automatic int pp_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pingpong_reader.sv
// Drains completed banks of the ping-pong register bank onto a valid/ready stream
// and returns each bank to the writer. Macro PP_READER_STATUS_EN adds the overrun flag.
module pingpong_reader
  import pp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_bank_done,
  input  logic                   wr_bank_sel,
  output logic [pp_aw(DEPTH):0]  mem_rd_addr,
  input  logic [WIDTH-1:0]       mem_rd_data,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   bank_free,
  output logic                   bank_free_sel
`ifdef PP_READER_STATUS_EN
  ,
  output logic                   overrun
`endif
);

  localparam int            AW       = pp_aw(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  pp_state_e        state_q, state_d;
  logic [1:0]       pend_q, pend_d;
  pp_bank_t         rd_bank_q, rd_bank_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             bank_free_q, bank_free_d;
  pp_bank_t         bank_free_sel_q, bank_free_sel_d;
  logic             handshake;
  logic             bank_release;
  logic             done_ignored;

  assign handshake = out_valid_q && out_ready;

  // A done for a bank that is queued or in flight is dropped; the writer owes us a bank_free first.
  assign done_ignored = wr_bank_done &&
                        (pend_q[wr_bank_sel] || ((state_q != IDLE) && (rd_bank_q == wr_bank_sel)));

  always_comb begin
    state_d         = state_q;
    pend_d          = pend_q;
    rd_bank_d       = rd_bank_q;
    idx_d           = idx_q;
    out_data_d      = out_data_q;
    out_valid_d     = out_valid_q;
    bank_free_d     = 1'b0;
    bank_free_sel_d = bank_free_sel_q;
    bank_release    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q[rd_bank_q]) begin
          idx_d   = '0;
          state_d = FETCH;
        end else if (pend_q[~rd_bank_q]) begin
          rd_bank_d = ~rd_bank_q;
          idx_d     = '0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        out_data_d  = mem_rd_data;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            bank_release    = 1'b1;
            bank_free_d     = 1'b1;
            bank_free_sel_d = rd_bank_q;
            rd_bank_d       = ~rd_bank_q;
            idx_d           = '0;
            state_d         = IDLE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An accepted done always targets the other bank than a same-cycle release.
    if (bank_release) pend_d[rd_bank_q] = 1'b0;
    if (wr_bank_done && !done_ignored) pend_d[wr_bank_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      pend_q          <= '0;
      rd_bank_q       <= 1'b0;
      idx_q           <= '0;
      out_data_q      <= '0;
      out_valid_q     <= 1'b0;
      bank_free_q     <= 1'b0;
      bank_free_sel_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_q          <= pend_d;
      rd_bank_q       <= rd_bank_d;
      idx_q           <= idx_d;
      out_data_q      <= out_data_d;
      out_valid_q     <= out_valid_d;
      bank_free_q     <= bank_free_d;
      bank_free_sel_q <= bank_free_sel_d;
    end
  end

  // Address follows next-state so the registered-read data is valid during FETCH.
  assign mem_rd_addr   = {rd_bank_d, idx_d};
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign bank_free     = bank_free_q;
  assign bank_free_sel = bank_free_sel_q;

`ifdef PP_READER_STATUS_EN
  logic overrun_q, overrun_d;

  assign overrun_d = overrun_q | done_ignored;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_pingpong_reader.sv
// Self-checking bench for pingpong_reader: directed timing scenarios plus a
// randomized run scored against a bank-level reference model.
module tb_pingpong_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_bank_done = 1'b0;
  logic             wr_bank_sel = 1'b0;
  logic             out_ready = 1'b0;
  logic [AW:0]      mem_rd_addr;
  logic [WIDTH-1:0] mem_rd_data;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             bank_free;
  logic             bank_free_sel;
`ifdef PP_READER_STATUS_EN
  logic             overrun;
`endif

  logic [WIDTH-1:0] mem [0:2*DEPTH-1];
  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  int hs_data_q[$];
  int hs_cyc_q[$];
  int free_sel_q[$];
  int free_cyc_q[$];

  pingpong_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_bank_done (wr_bank_done),
    .wr_bank_sel  (wr_bank_sel),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .bank_free    (bank_free),
    .bank_free_sel(bank_free_sel)
`ifdef PP_READER_STATUS_EN
    ,
    .overrun      (overrun)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Storage array with a registered read port.
  always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

  // Transaction monitor: one line per accepted word and per bank release.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        hs_data_q.push_back(int'(out_data));
        hs_cyc_q.push_back(cyc);
        $display("txn word  cyc=%0d data=%02h", cyc, out_data);
      end
      if (bank_free) begin
        free_sel_q.push_back(int'(bank_free_sel));
        free_cyc_q.push_back(cyc);
        $display("txn free  cyc=%0d sel=%0d", cyc, bank_free_sel);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    hs_data_q.delete();
    hs_cyc_q.delete();
    free_sel_q.delete();
    free_cyc_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_bank_done = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic send_done(input logic sel, output int t);
    wr_bank_done = 1'b1;
    wr_bank_sel  = sel;
    t = cyc;
    tick();
    wr_bank_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    nvec++; if (out_data !== '0) begin nerr++; $display("FAIL reset_out_data: got %02h expected 00", out_data); end
    nvec++; if (mem_rd_addr !== '0) begin nerr++; $display("FAIL reset_mem_rd_addr: got %0h expected 0", mem_rd_addr); end
    nvec++; if (bank_free !== 1'b0) begin nerr++; $display("FAIL reset_bank_free: got %b expected 0", bank_free); end
    nvec++; if (bank_free_sel !== 1'b0) begin nerr++; $display("FAIL reset_bank_free_sel: got %b expected 0", bank_free_sel); end
    nvec++; if (dut.pend_q !== 2'b00) begin nerr++; $display("FAIL reset_pend: got %b expected 00", dut.pend_q); end
    nvec++; if (dut.rd_bank_q !== 1'b0) begin nerr++; $display("FAIL reset_rd_bank: got %b expected 0", dut.rd_bank_q); end
    nvec++; if (dut.state_q !== pp_pkg::IDLE) begin nerr++; $display("FAIL reset_state: got %0d expected IDLE", dut.state_q); end
`ifdef PP_READER_STATUS_EN
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
`endif
    tick();
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic test_single_bank();
    int t0;
    do_reset();
    out_ready = 1'b1;
    send_done(1'b0, t0);
    repeat (14) tick();
    nvec++; if (hs_data_q.size() != DEPTH) begin nerr++; $display("FAIL single_count: got %0d words expected %0d", hs_data_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      nvec++;
      if (i >= hs_data_q.size()) begin
        nerr++; $display("FAIL single_word%0d: missing, expected %02h at cyc %0d", i, mem[i], t0 + 3 + 2*i);
      end else if (hs_data_q[i] !== int'(mem[i]) || hs_cyc_q[i] !== t0 + 3 + 2*i) begin
        nerr++; $display("FAIL single_word%0d: got %02h at cyc %0d expected %02h at cyc %0d", i, hs_data_q[i], hs_cyc_q[i], mem[i], t0 + 3 + 2*i);
      end
    end
    nvec++;
    if (free_cyc_q.size() != 1) begin
      nerr++; $display("FAIL single_free_count: got %0d expected 1", free_cyc_q.size());
    end else if (free_cyc_q[0] !== t0 + 10 || free_sel_q[0] !== 0) begin
      nerr++; $display("FAIL single_free: got sel %0d cyc %0d expected sel 0 cyc %0d", free_sel_q[0], free_cyc_q[0], t0 + 10);
    end
    nvec++; if (dut.rd_bank_q !== 1'b1) begin nerr++; $display("FAIL single_rd_bank: got %b expected 1", dut.rd_bank_q); end
  endtask

  task automatic test_bank1_first();
    int t0;
    do_reset();
    out_ready = 1'b1;
    send_done(1'b1, t0);
    repeat (14) tick();
    nvec++; if (hs_data_q.size() != DEPTH) begin nerr++; $display("FAIL bank1_count: got %0d words expected %0d", hs_data_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      nvec++;
      if (i >= hs_data_q.size()) begin
        nerr++; $display("FAIL bank1_word%0d: missing, expected %02h", i, mem[DEPTH + i]);
      end else if (hs_data_q[i] !== int'(mem[DEPTH + i]) || hs_cyc_q[i] !== t0 + 3 + 2*i) begin
        nerr++; $display("FAIL bank1_word%0d: got %02h at cyc %0d expected %02h at cyc %0d", i, hs_data_q[i], hs_cyc_q[i], mem[DEPTH + i], t0 + 3 + 2*i);
      end
    end
    nvec++;
    if (free_cyc_q.size() != 1) begin
      nerr++; $display("FAIL bank1_free_count: got %0d expected 1", free_cyc_q.size());
    end else if (free_sel_q[0] !== 1 || free_cyc_q[0] !== t0 + 10) begin
      nerr++; $display("FAIL bank1_free: got sel %0d cyc %0d expected sel 1 cyc %0d", free_sel_q[0], free_cyc_q[0], t0 + 10);
    end
    nvec++; if (dut.rd_bank_q !== 1'b0) begin nerr++; $display("FAIL bank1_rd_bank: got %b expected 0", dut.rd_bank_q); end
  endtask

  task automatic test_back_to_back();
    int t0, t1, ec, ei;
    do_reset();
    out_ready = 1'b1;
    send_done(1'b0, t0);
    send_done(1'b1, t1);
    repeat (24) tick();
    nvec++; if (hs_data_q.size() != 2*DEPTH) begin nerr++; $display("FAIL b2b_count: got %0d words expected %0d", hs_data_q.size(), 2*DEPTH); end
    for (int i = 0; i < 2*DEPTH; i++) begin
      ec = (i < DEPTH) ? t0 + 3 + 2*i : t0 + 12 + 2*(i - DEPTH);
      ei = i;
      nvec++;
      if (i >= hs_data_q.size()) begin
        nerr++; $display("FAIL b2b_word%0d: missing, expected %02h", i, mem[ei]);
      end else if (hs_data_q[i] !== int'(mem[ei]) || hs_cyc_q[i] !== ec) begin
        nerr++; $display("FAIL b2b_word%0d: got %02h at cyc %0d expected %02h at cyc %0d", i, hs_data_q[i], hs_cyc_q[i], mem[ei], ec);
      end
    end
    nvec++;
    if (free_cyc_q.size() != 2) begin
      nerr++; $display("FAIL b2b_free_count: got %0d expected 2", free_cyc_q.size());
    end else if (free_sel_q[0] !== 0 || free_cyc_q[0] !== t0 + 10 || free_sel_q[1] !== 1 || free_cyc_q[1] !== t0 + 19) begin
      nerr++; $display("FAIL b2b_free: got sel %0d@%0d sel %0d@%0d expected sel 0@%0d sel 1@%0d",
                       free_sel_q[0], free_cyc_q[0], free_sel_q[1], free_cyc_q[1], t0 + 10, t0 + 19);
    end
  endtask

  task automatic test_stall();
    int t0, ec;
    do_reset();
    out_ready = 1'b1;
    send_done(1'b0, t0);
    repeat (6) tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b1 || out_data !== mem[2]) begin
        nerr++; $display("FAIL stall_hold%0d: got valid %b data %02h expected valid 1 data %02h", k, out_valid, out_data, mem[2]);
      end
      tick();
    end
    out_ready = 1'b1;
    repeat (8) tick();
    nvec++; if (hs_data_q.size() != DEPTH) begin nerr++; $display("FAIL stall_count: got %0d words expected %0d", hs_data_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      ec = (i < 2) ? t0 + 3 + 2*i : t0 + 12 + 2*(i - 2);
      nvec++;
      if (i >= hs_data_q.size()) begin
        nerr++; $display("FAIL stall_word%0d: missing, expected %02h", i, mem[i]);
      end else if (hs_data_q[i] !== int'(mem[i]) || hs_cyc_q[i] !== ec) begin
        nerr++; $display("FAIL stall_word%0d: got %02h at cyc %0d expected %02h at cyc %0d", i, hs_data_q[i], hs_cyc_q[i], mem[i], ec);
      end
    end
    nvec++;
    if (free_cyc_q.size() != 1 || free_cyc_q[0] !== t0 + 15) begin
      nerr++; $display("FAIL stall_free: got %0d pulses expected 1 at cyc %0d", free_cyc_q.size(), t0 + 15);
    end
  endtask

  task automatic test_overrun();
    int t0, t1;
    do_reset();
    out_ready = 1'b1;
    send_done(1'b0, t0);
    repeat (3) tick();
    send_done(1'b0, t1);   // bank 0 is being read
    repeat (4) tick();
    send_done(1'b0, t1);   // coincides with the release of bank 0
    repeat (20) tick();
    @(negedge clk);
    nvec++; if (hs_data_q.size() != DEPTH) begin nerr++; $display("FAIL ovr_count: got %0d words expected %0d", hs_data_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      nvec++;
      if (i >= hs_data_q.size()) begin
        nerr++; $display("FAIL ovr_word%0d: missing, expected %02h", i, mem[i]);
      end else if (hs_data_q[i] !== int'(mem[i])) begin
        nerr++; $display("FAIL ovr_word%0d: got %02h expected %02h", i, hs_data_q[i], mem[i]);
      end
    end
    nvec++; if (free_cyc_q.size() != 1) begin nerr++; $display("FAIL ovr_free_count: got %0d expected 1", free_cyc_q.size()); end
    nvec++; if (dut.pend_q !== 2'b00) begin nerr++; $display("FAIL ovr_pend: got %b expected 00", dut.pend_q); end
`ifdef PP_READER_STATUS_EN
    nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    repeat (5) tick();
    @(negedge clk);
    nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    int t0;
    do_reset();
    out_ready = 1'b1;
    send_done(1'b0, t0);
    repeat (6) tick();
    rst = 1'b1;
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    nvec++; if (dut.pend_q !== 2'b00) begin nerr++; $display("FAIL rstmid_pend: got %b expected 00", dut.pend_q); end
    tick();
    rst = 1'b0;
    clear_obs();
    repeat (15) tick();
    nvec++;
    if (free_cyc_q.size() != 0 || hs_data_q.size() != 0) begin
      nerr++; $display("FAIL rstmid_quiet: got %0d frees %0d words expected 0 and 0", free_cyc_q.size(), hs_data_q.size());
    end
    send_done(1'b0, t0);
    repeat (14) tick();
    nvec++;
    if (hs_data_q.size() != DEPTH || hs_data_q[0] !== int'(mem[0]) || hs_cyc_q[0] !== t0 + 3) begin
      nerr++; $display("FAIL rstmid_restart: got %0d words expected %0d starting %02h at cyc %0d", hs_data_q.size(), DEPTH, mem[0], t0 + 3);
    end
    nvec++; if (free_cyc_q.size() != 1) begin nerr++; $display("FAIL rstmid_free: got %0d expected 1", free_cyc_q.size()); end
  endtask

  // Bank-level reference: pending set, preferred bank, words consumed from the bank in service.
  task automatic test_random();
    logic [1:0] m_pend = 2'b00;
    logic m_pref = 1'b0, m_bank = 1'b0, m_busy = 1'b0, m_over = 1'b0;
    logic exp_free = 1'b0, exp_free_sel = 1'b0, rel;
    int m_word = 0, words = 0, banks = 0;
    bit drive;
    for (int i = 0; i < 2*DEPTH; i++) mem[i] = WIDTH'($urandom);
    do_reset();
    for (int c = 0; c < 640; c++) begin
      drive = (c < 560);
      wr_bank_done = drive && ($urandom_range(0, 5) == 0);
      wr_bank_sel  = 1'($urandom_range(0, 1));
      out_ready    = !drive || ($urandom_range(0, 9) < 7);
      @(negedge clk);
      nvec++;
      if (bank_free !== exp_free) begin nerr++; $display("FAIL rnd_free c%0d: got %b expected %b", c, bank_free, exp_free); end
      if (exp_free) begin
        nvec++;
        if (bank_free_sel !== exp_free_sel) begin nerr++; $display("FAIL rnd_free_sel c%0d: got %b expected %b", c, bank_free_sel, exp_free_sel); end
      end
`ifdef PP_READER_STATUS_EN
      nvec++;
      if (overrun !== m_over) begin nerr++; $display("FAIL rnd_overrun c%0d: got %b expected %b", c, overrun, m_over); end
`endif
      exp_free = 1'b0;
      rel = 1'b0;
      if (!m_busy) begin
        nvec++;
        if (out_valid !== 1'b0) begin nerr++; $display("FAIL rnd_idle_valid c%0d: got %b expected 0", c, out_valid); end
        if (m_pend != 2'b00) begin
          m_bank = m_pend[m_pref] ? m_pref : ~m_pref;
          m_busy = 1'b1;
          m_word = 0;
        end
      end else if (out_valid && out_ready) begin
        nvec++;
        if (out_data !== mem[int'(m_bank)*DEPTH + m_word]) begin
          nerr++; $display("FAIL rnd_data c%0d: got %02h expected %02h (bank %0d word %0d)", c, out_data, mem[int'(m_bank)*DEPTH + m_word], m_bank, m_word);
        end
        m_word++;
        words++;
        if (m_word == DEPTH) rel = 1'b1;
      end
      if (wr_bank_done) begin
        if (m_pend[wr_bank_sel]) m_over = 1'b1;
        else m_pend[wr_bank_sel] = 1'b1;
      end
      if (rel) begin
        m_pend[m_bank] = 1'b0;
        m_busy   = 1'b0;
        m_pref   = ~m_bank;
        exp_free = 1'b1;
        exp_free_sel = m_bank;
        banks++;
      end
      tick();
    end
    wr_bank_done = 1'b0;
    @(negedge clk);
    nvec++;
    if (m_busy || dut.pend_q !== 2'b00 || words != banks * DEPTH || banks == 0) begin
      nerr++; $display("FAIL rnd_drain: pend %b, model busy %b, %0d words over %0d banks", dut.pend_q, m_busy, words, banks);
    end
  endtask

  initial begin
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[4] = 8'hA5; mem[5] = 8'h5A; mem[6] = 8'hC3; mem[7] = 8'h3C;
    test_reset();
    test_single_bank();
    test_bank1_first();
    test_back_to_back();
    test_stall();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
